axis_traffic_gen_chk: RTL



---
 rtl/axis_tg_pkg.sv | 18 +
 rtl/axis_lfsr16.sv | 19 +
 rtl/axis_traffic_gen_chk.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_tg_pkg.sv
// Shared types and helpers for the AXI-Stream traffic generator/checker.
package axis_tg_pkg;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          MAX_WPB   = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  // Contiguous keep mask with the lowest `len` lanes set.
  function automatic logic [MAX_WPB-1:0] last_keep(input int unsigned len);
    return (len >= MAX_WPB) ? '1 : ((64'd1 << len) - 64'd1);
  endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Galois LFSR, free-running from its seed after reset.
module axis_lfsr16
  import axis_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        areset,
  output logic [15:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= SEED;
    else        state <= (state >> 1) ^ (state[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/axis_traffic_gen_chk.sv
// AXI-Stream incrementing-word generator and matching checker with
// LFSR-throttled valid/ready, for stream datapath bring-up.
module axis_traffic_gen_chk
  import axis_tg_pkg::*;
#(
  parameter int          WORD_WIDTH = 8,
  parameter int          BUS_WIDTH  = 8,
  parameter int          PROB_VALID = 200,
  parameter int          PROB_READY = 200,
  parameter int          LEN_W      = 16,
  parameter int          PKT_W      = 8,
  parameter int          ERR_W      = 16,
  parameter logic [15:0] SEED_V     = 16'hACE1,
  parameter logic [15:0] SEED_R     = 16'h1D2B,
  localparam int         WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      start,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic [PKT_W-1:0]          cfg_pkts,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [BUS_WIDTH-1:0]      m_axis_tdata,
  output logic [WORDS_PER_BEAT-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [BUS_WIDTH-1:0]      s_axis_tdata,
  input  logic [WORDS_PER_BEAT-1:0] s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      busy,
  output logic                      done,
  output logic [ERR_W-1:0]          err_count
);

  localparam logic [LEN_W-1:0] WPB_L = LEN_W'(WORDS_PER_BEAT);
  localparam logic [10:0]      PV    = 11'(PROB_VALID);
  localparam logic [10:0]      PR    = 11'(PROB_READY);

  state_t state;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      lfsr_v, lfsr_r;
  logic             draw_v, draw_r, start_ok;
  logic             unused_bits;

  axis_lfsr16 #(.SEED(SEED_V)) u_lfsr_v (.aclk(aclk), .areset(areset), .state(lfsr_v));
  axis_lfsr16 #(.SEED(SEED_R)) u_lfsr_r (.aclk(aclk), .areset(areset), .state(lfsr_r));

  assign draw_v   = {1'b0, lfsr_v[9:0]} < PV;
  assign draw_r   = {1'b0, lfsr_r[9:0]} < PR;
  assign start_ok = (state == ST_IDLE) && start;

  // Generator: counters describe the next beat to be loaded into the output register.
  logic [WORD_WIDTH-1:0]     gen_cnt;
  logic [LEN_W-1:0]          gen_rem, gen_n;
  logic [PKT_W-1:0]          gen_pkts;
  logic                      gen_last, gen_load, gen_fin;
  logic [MAX_WPB-1:0]        gen_mask;
  logic [WORDS_PER_BEAT-1:0] gen_keep;
  logic [BUS_WIDTH-1:0]      gen_data;

  assign gen_last = gen_rem <= WPB_L;
  assign gen_n    = gen_last ? gen_rem : WPB_L;
  assign gen_mask = last_keep(32'(gen_n));
  assign gen_keep = gen_mask[WORDS_PER_BEAT-1:0];
  assign gen_load = (state == ST_RUN) && (gen_pkts != '0)
                    && (!m_axis_tvalid || m_axis_tready) && draw_v;
  assign gen_fin  = (gen_pkts == '0) && (!m_axis_tvalid || m_axis_tready);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gen_data = '0;
    for (int i = 0; i < WORDS_PER_BEAT; i++)
      if (gen_keep[i]) gen_data[i*WORD_WIDTH +: WORD_WIDTH] = gen_cnt + WORD_WIDTH'(i);
  end

  // Checker: independent model of the same word sequence.
  logic [WORD_WIDTH-1:0]     chk_cnt;
  logic [LEN_W-1:0]          chk_rem, exp_n;
  logic [PKT_W-1:0]          chk_pkts, chk_pkts_nxt;
  logic                      s_hs, exp_last, chk_last_hs, chk_fin;
  logic                      data_err, keep_err, last_err;
  logic [MAX_WPB-1:0]        exp_mask;
  logic [WORDS_PER_BEAT-1:0] exp_keep;
  logic [1:0]                err_inc;
  logic [ERR_W:0]            err_sum;
  logic [ERR_W-1:0]          err_next;

  assign s_hs         = s_axis_tvalid && s_axis_tready;
  assign exp_last     = chk_rem <= WPB_L;
  assign exp_n        = exp_last ? chk_rem : WPB_L;
  assign exp_mask     = last_keep(32'(exp_n));
  assign exp_keep     = exp_mask[WORDS_PER_BEAT-1:0];
  assign chk_last_hs  = s_hs && exp_last;
  assign chk_pkts_nxt = chk_pkts - PKT_W'(chk_last_hs);
  assign chk_fin      = (chk_pkts == '0) || (chk_last_hs && chk_pkts == PKT_W'(1));

  always_comb begin
    data_err = 1'b0;
    for (int i = 0; i < WORDS_PER_BEAT; i++)
      if (s_axis_tkeep[i] &&
          (s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH] != chk_cnt + WORD_WIDTH'(i)))
        data_err = 1'b1;
  end

  assign keep_err = s_axis_tkeep != exp_keep;
  assign last_err = s_axis_tlast != exp_last;
  assign err_inc  = {1'b0, data_err} + {1'b0, keep_err} + {1'b0, last_err};
  assign err_sum  = {1'b0, err_count} + {{(ERR_W-1){1'b0}}, err_inc};
  assign err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

  assign unused_bits = ^{lfsr_v[15:10], lfsr_r[15:10], gen_mask, exp_mask};

  // Control FSM. A zero-sized run spends one silent FINISH cycle before its done pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      len_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            len_q <= cfg_len;
            if (cfg_len != '0 && cfg_pkts != '0) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_RUN: begin
          if (gen_fin && chk_fin) begin
            state <= ST_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_FINISH: begin
          if (done) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      gen_cnt       <= '0;
      gen_rem       <= '0;
      gen_pkts      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (start_ok) begin
      gen_cnt       <= '0;
      gen_rem       <= cfg_len;
      gen_pkts      <= (cfg_len != '0) ? cfg_pkts : '0;
      m_axis_tvalid <= 1'b0;
    end else if (!m_axis_tvalid || m_axis_tready) begin
      m_axis_tvalid <= gen_load;
      if (gen_load) begin
        m_axis_tdata <= gen_data;
        m_axis_tkeep <= gen_keep;
        m_axis_tlast <= gen_last;
        gen_cnt      <= gen_cnt + WORD_WIDTH'(gen_n);
        if (gen_last) begin
          gen_rem  <= len_q;
          gen_pkts <= gen_pkts - PKT_W'(1);
        end else begin
          gen_rem  <= gen_rem - WPB_L;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      chk_cnt       <= '0;
      chk_rem       <= '0;
      chk_pkts      <= '0;
      s_axis_tready <= 1'b0;
      err_count     <= '0;
    end else begin
      s_axis_tready <= (state == ST_RUN) && (chk_pkts_nxt != '0) && draw_r;
      if (start_ok) begin
        chk_cnt   <= '0;
        chk_rem   <= cfg_len;
        chk_pkts  <= (cfg_len != '0) ? cfg_pkts : '0;
        err_count <= '0;
      end else if (s_hs) begin
        chk_cnt   <= chk_cnt + WORD_WIDTH'(exp_n);
        err_count <= err_next;
        if (exp_last) begin
          chk_rem  <= len_q;
          chk_pkts <= chk_pkts_nxt;
        end else begin
          chk_rem  <= chk_rem - WPB_L;
        end
      end
    end
  end

endmodule
